muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer for the shared multiply/divide resource of the multicycle CPU. It accepts one MULT/DIV request at a time from the control unit and pulses the start input of the selected unit. It waits the unit's fixed latency, then commits the result into HI/LO by driving the HI/LO write enables and the HI/LO source-mux select. It also traps divide-by-zero before the divider is started, and reports completion to the control unit with a busy/done handshake.

## Interface
- MULT_CYCLES, 32: cycles from the mult start pulse to a valid mult HI/LO output; must be ≥1.
- DIV_CYCLES, 32: cycles from the div start pulse to a valid div HI/LO output; must be ≥1.
- CNT_W, 6: width of the latency counter; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  request from the control unit; sampled only in IDLE.
- op  in  1  0 = MULT, 1 = DIV; sampled with start.
- B_in  in  32  divisor (B register output); sampled with start.
- flush  in  1  synchronous abort; returns the block to IDLE with no HI/LO write.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- div_start  out  1  one-cycle start pulse to the divider.
- HiLoSrc  out  1  HI/LO mux select: 0 = divider result, 1 = multiplier result.
- HI_write  out  1  HI register write enable.
- LO_write  out  1  LO register write enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- div0  out  1  divide-by-zero flag; pulses together with done.

## Operation
- States: IDLE, LAUNCH, WAIT, WRITE, DONE, ERR.
- All outputs are Moore outputs decoded from the registered state and op_q. There are no combinational paths from inputs to outputs.
- IDLE:
  - If start=1, latch op into op_q.
  - If op=1 and B_in==0, go to ERR.
  - Otherwise go to LAUNCH.
  - If start=0, stay in IDLE.
- LAUNCH:
  - mult_start=~op_q and div_start=op_q, for exactly one cycle.
  - Load cnt with MULT_CYCLES or DIV_CYCLES, according to op_q.
  - Go to WAIT.
- WAIT:
  - Decrement cnt each cycle.
  - Leave for WRITE on the cycle cnt==1, so WAIT lasts exactly LAT cycles.
- WRITE: HI_write=LO_write=1 for one cycle, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- ERR:
  - done=1 and div0=1 for one cycle; no start pulse and no HI/LO write.
  - Go to IDLE.
- HiLoSrc = ~op_q in every state. It holds its value after completion.
- start while busy is ignored. It is not queued; the control unit must wait for done.
- flush=1 in any non-IDLE state: next state is IDLE and cnt is cleared.
  - No HI_write, LO_write or done is produced for the aborted operation.
  - flush has priority over every other transition.
  - flush together with start in IDLE: flush wins and start is ignored.
- A start pulse to a unit already issued is not recalled by flush. The unit may keep running, but its result is never committed.
- The counter wraps are unreachable by construction. cnt only decrements in WAIT and is ≥1 there.

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, op_q=0.
  - mult_start, div_start, HI_write, LO_write, busy, done and div0 are all 0.
  - HiLoSrc is 1 (since op_q=0).
- Reset asserted mid-operation aborts immediately; no write or done follows.
- Normal request, with start high in IDLE during cycle 0:
  - Cycle 1 is LAUNCH, with the unit start pulse.
  - Cycles 2 to LAT+1 are WAIT.
  - Cycle LAT+2 is WRITE, with the HI/LO enables.
  - Cycle LAT+3 is DONE.
  - Cycle LAT+4 is IDLE; a new start is accepted in that cycle.
- busy is high in cycles 1 to LAT+3.
- Div-by-zero: cycle 1 is ERR (busy=done=div0=1); cycle 2 is IDLE.
- Back-to-back: start held high continuously issues the next operation from the IDLE cycle after DONE. There is a minimum gap of one IDLE cycle between operations.

## Test plan
- MULT with defaults: reset released, start=1, op=0, B_in=5 in cycle 0.
  - mult_start=1 only in cycle 1; div_start stays 0.
  - HI_write=LO_write=1 with HiLoSrc=1 only in cycle 34.
  - done=1 only in cycle 35; busy high in cycles 1 to 35; div0 stays 0.
- DIV with B_in=7, op=1:
  - div_start pulses in cycle 1.
  - HiLoSrc=0 from cycle 1 onward; write in cycle 34; done in cycle 35.
- DIV with B_in=0:
  - done=div0=busy=1 in cycle 1 only.
  - No start pulse and no HI_write/LO_write; IDLE in cycle 2.
- Flush mid-WAIT: MULT started, flush=1 in cycle 10.
  - Cycle 11 is IDLE; busy=0 from cycle 11.
  - No HI_write or done; a new DIV started in cycle 11 completes normally (done in cycle 46).
- start toggled every cycle during a MULT:
  - Exactly one mult_start and one done are produced.
  - A start held high through cycle 36 launches a second operation in cycle 37.
- Async reset asserted in cycle 20 of a DIV:
  - All outputs go to 0 at once, with HiLoSrc=1.
  - No write or done occurs after reset is released.

Source files
------------

// File: rtl/muldiv_if.sv
// muldiv_if: request/handshake and HI/LO commit bundle between control unit and muldiv_ctrl.
interface muldiv_if;
    logic        start;
    logic        op;
    logic [31:0] B_in;
    logic        flush;
    logic        mult_start;
    logic        div_start;
    logic        HiLoSrc;
    logic        HI_write;
    logic        LO_write;
    logic        busy;
    logic        done;
    logic        div0;
    modport master (
        output start, op, B_in, flush,
        input  mult_start, div_start, HiLoSrc, HI_write, LO_write, busy, done, div0
    );
    modport slave (
        input  start, op, B_in, flush,
        output mult_start, div_start, HiLoSrc, HI_write, LO_write, busy, done, div0
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one MULT/DIV through launch, fixed-latency wait and HI/LO commit.
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input logic clk,
    input logic rst_n,
    muldiv_if.slave m
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, WRITE, DONE, ERR} state_t;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic [7:0]         out_q, out_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE: if (m.start) begin
                op_d    = m.op;
                state_d = (m.op && m.B_in == 32'd0) ? ERR : LAUNCH;
            end
            LAUNCH: begin
                cnt_d   = op_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CNT_W'(1)) ? WRITE : WAIT;
            end
            WRITE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
        // Abort wins everywhere, including a start arriving in IDLE.
        if (m.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            op_d    = op_q;
        end
    end
    // Outputs are registered from the next state so they track state_q exactly.
    always_comb begin
        out_d = {
            state_d == LAUNCH && !op_d,
            state_d == LAUNCH && op_d,
            !op_d,
            state_d == WRITE,
            state_d == WRITE,
            state_d != IDLE,
            state_d == DONE || state_d == ERR,
            state_d == ERR
        };
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            out_q   <= 8'b0010_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            out_q   <= out_d;
        end
    end
    assign {m.mult_start, m.div_start, m.HiLoSrc, m.HI_write, m.LO_write, m.busy, m.done, m.div0} = out_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and random scenarios checked against a cycles-since-accept timeline model.
module tb_muldiv_ctrl;
    localparam int MULT_LAT = 32;
    localparam int DIV_LAT  = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    muldiv_if m ();
    muldiv_ctrl #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .m(m)
    );
    always #5 clk = ~clk;
    // Reference: an operation is described by how many cycles ago it was accepted.
    bit m_busy, m_op, m_err, m_hilo = 1'b1;
    int m_t;
    function automatic int lat(bit o);
        return o ? DIV_LAT : MULT_LAT;
    endfunction
    task automatic model_edge();
        if (!rst_n) begin
            m_busy = 0; m_t = 0; m_op = 0; m_err = 0; m_hilo = 1;
        end else if (m_busy) begin
            if (m.flush) m_busy = 0;
            else begin
                m_t++;
                if (m_t > (m_err ? 1 : lat(m_op) + 3)) m_busy = 0;
            end
        end else if (m.start && !m.flush) begin
            m_busy = 1; m_t = 1; m_op = m.op; m_err = m.op && (m.B_in == 32'd0); m_hilo = !m.op;
        end
    endtask
    function automatic logic [7:0] mdl_o();
        logic w;
        w = m_busy && !m_err && m_t == lat(m_op) + 2;
        return {m_busy && !m_err && m_t == 1 && !m_op, m_busy && !m_err && m_t == 1 && m_op, m_hilo, w, w,
                m_busy, m_busy && (m_err ? m_t == 1 : m_t == lat(m_op) + 3), m_busy && m_err};
    endfunction
    function automatic logic [7:0] dut_o();
        return {m.mult_start, m.div_start, m.HiLoSrc, m.HI_write, m.LO_write, m.busy, m.done, m.div0};
    endfunction
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask
    task automatic test_reset();
        m.start = 0; m.op = 0; m.B_in = 0; m.flush = 0; rst_n = 0;
        tick(); tick();
        n_chk++;
        if (dut_o() !== 8'b0010_0000) begin n_fail++; $display("FAIL reset: got %b exp 00100000", dut_o()); end
        rst_n = 1;
        tick();
        n_chk++;
        if (dut_o() !== mdl_o()) begin n_fail++; $display("FAIL reset_idle: got %b exp %b", dut_o(), mdl_o()); end
    endtask
    task automatic test_mult();
        int wr_c = -1, wr_n = 0, dn_c = -1, dn_n = 0, ms = 0, ds = 0, bz = 0, d0 = 0;
        m.start = 1; m.op = 0; m.B_in = 5;
        for (int c = 1; c <= 40; c++) begin
            tick();
            m.start = 0;
            n_chk++;
            if (dut_o() !== mdl_o()) begin n_fail++; $display("FAIL mult cyc %0d: got %b exp %b", c, dut_o(), mdl_o()); end
            if (m.HI_write && m.LO_write && m.HiLoSrc) begin wr_c = c; wr_n++; end
            if (m.done) begin dn_c = c; dn_n++; end
            ms += m.mult_start; ds += m.div_start; bz += m.busy; d0 += m.div0;
        end
        n_chk++;
        if (wr_c != 34 || wr_n != 1) begin n_fail++; $display("FAIL mult_write: got cyc %0d n %0d exp cyc 34 n 1", wr_c, wr_n); end
        n_chk++;
        if (dn_c != 35 || dn_n != 1) begin n_fail++; $display("FAIL mult_done: got cyc %0d n %0d exp cyc 35 n 1", dn_c, dn_n); end
        n_chk++;
        if (ms != 1 || ds != 0 || bz != 35 || d0 != 0) begin
            n_fail++; $display("FAIL mult_counts: got ms %0d ds %0d busy %0d div0 %0d exp 1 0 35 0", ms, ds, bz, d0);
        end
    endtask
    task automatic test_div();
        int ds_c = -1, wr_c = -1, dn_c = -1, hl_bad = 0;
        m.start = 1; m.op = 1; m.B_in = 7;
        for (int c = 1; c <= 40; c++) begin
            tick();
            m.start = 0;
            n_chk++;
            if (dut_o() !== mdl_o()) begin n_fail++; $display("FAIL div cyc %0d: got %b exp %b", c, dut_o(), mdl_o()); end
            if (m.div_start) ds_c = c;
            if (m.HI_write) wr_c = c;
            if (m.done) dn_c = c;
            if (m.HiLoSrc !== 1'b0) hl_bad++;
        end
        n_chk++;
        if (ds_c != 1 || wr_c != 34 || dn_c != 35 || hl_bad != 0) begin
            n_fail++; $display("FAIL div_timeline: got start %0d write %0d done %0d hilo_bad %0d exp 1 34 35 0", ds_c, wr_c, dn_c, hl_bad);
        end
    endtask
    task automatic test_div0();
        int dn = 0, d0 = 0, bz = 0, st = 0, wr = 0;
        logic d_c1;
        m.start = 1; m.op = 1; m.B_in = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            m.start = 0;
            n_chk++;
            if (dut_o() !== mdl_o()) begin n_fail++; $display("FAIL div0 cyc %0d: got %b exp %b", c, dut_o(), mdl_o()); end
            if (c == 1) d_c1 = m.done && m.div0 && m.busy;
            dn += m.done; d0 += m.div0; bz += m.busy; st += m.mult_start + m.div_start; wr += m.HI_write + m.LO_write;
        end
        n_chk++;
        if (d_c1 !== 1'b1 || dn != 1 || d0 != 1 || bz != 1 || st != 0 || wr != 0) begin
            n_fail++; $display("FAIL div0_pulse: got c1 %b done %0d div0 %0d busy %0d starts %0d writes %0d exp 1 1 1 1 0 0", d_c1, dn, d0, bz, st, wr);
        end
    endtask
    task automatic test_flush();
        int early = 0, dn_c = -1;
        logic b11 = 1'b1;
        m.start = 1; m.op = 0; m.B_in = 3;
        for (int c = 1; c <= 60; c++) begin
            tick();
            n_chk++;
            if (dut_o() !== mdl_o()) begin n_fail++; $display("FAIL flush cyc %0d: got %b exp %b", c, dut_o(), mdl_o()); end
            if (c <= 11) early += m.HI_write + m.done;
            if (c == 11) b11 = m.busy;
            if (c > 11 && m.done) dn_c = c;
            m.start = (c == 11);
            m.flush = (c == 10);
            if (c == 11) begin m.op = 1; m.B_in = $urandom_range(1, 32'hFFFF_FFFF); end
        end
        n_chk++;
        if (b11 !== 1'b0 || early != 0 || dn_c != 46) begin
            n_fail++; $display("FAIL flush_abort: got busy11 %b early %0d done %0d exp 0 0 46", b11, early, dn_c);
        end
    endtask
    task automatic test_toggle();
        int ms = 0, dn = 0;
        logic ms37 = 1'b0;
        m.op = 0; m.B_in = 3;
        for (int c = 1; c <= 40; c++) begin
            m.start = ((c - 1) % 2 == 0);
            tick();
            n_chk++;
            if (dut_o() !== mdl_o()) begin n_fail++; $display("FAIL toggle cyc %0d: got %b exp %b", c, dut_o(), mdl_o()); end
            if (c <= 36) begin ms += m.mult_start; dn += m.done; end
            if (c == 37) ms37 = m.mult_start;
        end
        n_chk++;
        if (ms != 1 || dn != 1 || ms37 !== 1'b1) begin
            n_fail++; $display("FAIL toggle_ignore: got starts %0d dones %0d relaunch37 %b exp 1 1 1", ms, dn, ms37);
        end
        m.start = 0; m.flush = 1;
        tick();
        m.flush = 0;
    endtask
    task automatic test_async_reset();
        int post = 0;
        m.start = 1; m.op = 1; m.B_in = 9;
        for (int c = 1; c <= 20; c++) begin
            tick();
            m.start = 0;
            n_chk++;
            if (dut_o() !== mdl_o()) begin n_fail++; $display("FAIL areset cyc %0d: got %b exp %b", c, dut_o(), mdl_o()); end
        end
        rst_n = 0;
        #1;
        n_chk++;
        if (dut_o() !== 8'b0010_0000) begin n_fail++; $display("FAIL areset_now: got %b exp 00100000", dut_o()); end
        tick(); tick();
        rst_n = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            n_chk++;
            if (dut_o() !== mdl_o()) begin n_fail++; $display("FAIL areset_after cyc %0d: got %b exp %b", c, dut_o(), mdl_o()); end
            post += m.HI_write + m.LO_write + m.done;
        end
        n_chk++;
        if (post != 0) begin n_fail++; $display("FAIL areset_quiet: got %0d events exp 0", post); end
    endtask
    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            m.start = ($urandom_range(0, 3) != 0);
            m.op = $urandom_range(0, 1);
            m.B_in = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            m.flush = ($urandom_range(0, 40) == 0);
            tick();
            n_chk++;
            if (dut_o() !== mdl_o()) begin n_fail++; $display("FAIL random cyc %0d: got %b exp %b", c, dut_o(), mdl_o()); end
        end
        m.start = 0; m.flush = 0;
    endtask
    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_flush();
        test_toggle();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
